// File: rtl/arp_cache_aged.sv
// arp_cache_aged
//   ARP cache holding ENTRY_DEPTH IP->MAC bindings. Each binding has a valid
//   bit and an age counter. Writes refresh an existing binding in place, else
//   take the lowest free slot, else evict round-robin via a victim pointer.
//   Bindings expire after MAX_AGE aging strobes without a refresh. Lookups are
//   registered: a request in cycle N is answered in cycle N+1 and always sees
//   the contents as they were before any same-cycle write, flush or tick.
//
// Ports
//   i_sys_clk        system clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_lookup_en      lookup request (one per asserted cycle)
//   i_lookup_ip      IP to resolve
//   o_lookup_done    one-cycle pulse, result valid
//   o_lookup_result  1 = hit, 0 = miss
//   o_lookup_mac     MAC on hit, 0 otherwise
//   i_cache_w_en     learn/refresh a binding
//   i_cache_w_ip     binding IP
//   i_cache_w_mac    binding MAC
//   i_age_tick       aging strobe
//   i_flush          invalidate all entries
//   o_entry_count    number of valid entries
module arp_cache_aged #(
  parameter int ENTRY_DEPTH = 8,
  parameter int IP_W        = 32,
  parameter int MAC_W       = 48,
  parameter int MAX_AGE     = 300
) (
  input  logic                             i_sys_clk,
  input  logic                             i_rst,
  input  logic                             i_lookup_en,
  input  logic [IP_W-1:0]                  i_lookup_ip,
  output logic                             o_lookup_done,
  output logic                             o_lookup_result,
  output logic [MAC_W-1:0]                 o_lookup_mac,
  input  logic                             i_cache_w_en,
  input  logic [IP_W-1:0]                  i_cache_w_ip,
  input  logic [MAC_W-1:0]                 i_cache_w_mac,
  input  logic                             i_age_tick,
  input  logic                             i_flush,
  output logic [$clog2(ENTRY_DEPTH+1)-1:0] o_entry_count
);

  localparam int AGE_W = $clog2(MAX_AGE + 1);
  localparam int CNT_W = $clog2(ENTRY_DEPTH + 1);
  localparam int PTR_W = $clog2(ENTRY_DEPTH);

  logic [ENTRY_DEPTH-1:0] valid_q, valid_d;
  logic [AGE_W-1:0]       age_q [ENTRY_DEPTH];
  logic [AGE_W-1:0]       age_d [ENTRY_DEPTH];
  logic [IP_W-1:0]        ip_q  [ENTRY_DEPTH];
  logic [IP_W-1:0]        ip_d  [ENTRY_DEPTH];
  logic [MAC_W-1:0]       mac_q [ENTRY_DEPTH];
  logic [MAC_W-1:0]       mac_d [ENTRY_DEPTH];
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_p1;

  logic                   lk_hit_p0;
  logic [MAC_W-1:0]       lk_mac_p0;
  logic                   vld_p1;
  logic                   lk_hit_p1;
  logic [MAC_W-1:0]       lk_mac_p1;

  logic                   wr_act;
  logic                   wr_match;
  logic [PTR_W-1:0]       wr_match_idx;
  logic                   free_found;
  logic [PTR_W-1:0]       free_idx;
  logic [PTR_W-1:0]       wr_idx;

  function automatic logic [CNT_W-1:0] popcount(input logic [ENTRY_DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ENTRY_DEPTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Stage p0: lookup match against current (pre-update) contents.
  // At most one valid entry per IP exists, so OR-merging the MACs is safe.
  always_comb begin
    lk_hit_p0 = 1'b0;
    lk_mac_p0 = '0;
    for (int i = 0; i < ENTRY_DEPTH; i++) begin
      if (valid_q[i] && (ip_q[i] == i_lookup_ip)) begin
        lk_hit_p0 = 1'b1;
        lk_mac_p0 = lk_mac_p0 | mac_q[i];
      end
    end
  end

  // Write slot selection: refresh match, else lowest free slot, else victim.
  always_comb begin
    wr_match     = 1'b0;
    wr_match_idx = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    for (int i = 0; i < ENTRY_DEPTH; i++) begin
      if (valid_q[i] && (ip_q[i] == i_cache_w_ip)) begin
        wr_match     = 1'b1;
        wr_match_idx = PTR_W'(i);
      end
    end
    // Descending scan so the lowest free index is the last one kept.
    for (int i = ENTRY_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
    wr_act = i_cache_w_en && !i_flush;
    if (wr_match)        wr_idx = wr_match_idx;
    else if (free_found) wr_idx = free_idx;
    else                 wr_idx = ptr_q;
  end

  // Next-state: flush > write > aging.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    ip_d    = ip_q;
    mac_d   = mac_q;
    ptr_d   = ptr_q;
    if (i_flush) begin
      ptr_d = '0;
    end else if (wr_act && !wr_match && !free_found) begin
      ptr_d = (ptr_q == PTR_W'(ENTRY_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
    for (int i = 0; i < ENTRY_DEPTH; i++) begin
      if (i_flush) begin
        valid_d[i] = 1'b0;
        age_d[i]   = '0;
      end else if (wr_act && (wr_idx == PTR_W'(i))) begin
        valid_d[i] = 1'b1;
        age_d[i]   = '0;
        ip_d[i]    = i_cache_w_ip;
        mac_d[i]   = i_cache_w_mac;
      end else if (i_age_tick && valid_q[i]) begin
        if (age_q[i] == AGE_W'(MAX_AGE - 1)) begin
          valid_d[i] = 1'b0;
          age_d[i]   = '0;
        end else begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  // Stage p1: registered table state and lookup response.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= '0;
      ptr_q     <= '0;
      cnt_p1    <= '0;
      vld_p1    <= 1'b0;
      lk_hit_p1 <= 1'b0;
      lk_mac_p1 <= '0;
      for (int i = 0; i < ENTRY_DEPTH; i++) begin
        age_q[i] <= '0;
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      cnt_p1    <= popcount(valid_d);
      vld_p1    <= i_lookup_en;
      lk_hit_p1 <= i_lookup_en && lk_hit_p0;
      lk_mac_p1 <= (i_lookup_en && lk_hit_p0) ? lk_mac_p0 : '0;
      for (int i = 0; i < ENTRY_DEPTH; i++) begin
        age_q[i] <= age_d[i];
        ip_q[i]  <= ip_d[i];
        mac_q[i] <= mac_d[i];
      end
    end
  end

  assign o_lookup_done   = vld_p1;
  assign o_lookup_result = lk_hit_p1;
  assign o_lookup_mac    = lk_mac_p1;
  assign o_entry_count   = cnt_p1;

endmodule

// File: tb/tb_arp_cache_aged.sv
module tb_arp_cache_aged;

  localparam int DEPTH   = 8;
  localparam int MAX_AGE = 3;

  logic        clk;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_ip;
  logic        lookup_done;
  logic        lookup_result;
  logic [47:0] lookup_mac;
  logic        w_en;
  logic [31:0] w_ip;
  logic [47:0] w_mac;
  logic        age_tick;
  logic        flush;
  logic [3:0]  entry_count;

  int n_checks = 0;
  int n_fail   = 0;

  arp_cache_aged #(
    .ENTRY_DEPTH(DEPTH), .IP_W(32), .MAC_W(48), .MAX_AGE(MAX_AGE)
  ) dut (
    .i_sys_clk(clk), .i_rst(rst),
    .i_lookup_en(lookup_en), .i_lookup_ip(lookup_ip),
    .o_lookup_done(lookup_done), .o_lookup_result(lookup_result),
    .o_lookup_mac(lookup_mac),
    .i_cache_w_en(w_en), .i_cache_w_ip(w_ip), .i_cache_w_mac(w_mac),
    .i_age_tick(age_tick), .i_flush(flush),
    .o_entry_count(entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a binding lives as long as fewer than MAX_AGE ticks
  // have passed since it was last written.
  bit          m_valid [DEPTH];
  logic [31:0] m_ip    [DEPTH];
  logic [47:0] m_mac   [DEPTH];
  int          m_ticks [DEPTH];
  int          m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_ip[i] = '0; m_mac[i] = '0; m_ticks[i] = 0;
    end
    m_ptr = 0;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic void model_lookup(input logic [31:0] ip, output bit hit, output logic [47:0] mac);
    hit = 0; mac = '0;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_ip[i] == ip) begin hit = 1; mac = m_mac[i]; end
  endfunction

  function automatic void model_update(input bit we, input logic [31:0] ip, input logic [47:0] mac,
                                       input bit tick, input bit fl);
    int tgt;
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_ticks[i] = 0; end
      m_ptr = 0;
      return;
    end
    tgt = -1;
    if (we) begin
      for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_ip[i] == ip) tgt = i;
      if (tgt < 0)
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && tgt < 0) tgt = i;
      if (tgt < 0) begin
        tgt = m_ptr;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == tgt) begin
        m_valid[i] = 1; m_ticks[i] = 0; m_ip[i] = ip; m_mac[i] = mac;
      end else if (tick && m_valid[i]) begin
        m_ticks[i]++;
        if (m_ticks[i] >= MAX_AGE) begin m_valid[i] = 0; m_ticks[i] = 0; end
      end
    end
  endfunction

  task automatic step(input bit le, input logic [31:0] lip, input bit we, input logic [31:0] wip,
                      input logic [47:0] wmac, input bit tick, input bit fl);
    bit          e_hit;
    logic [47:0] e_mac;
    @(negedge clk);
    lookup_en = le; lookup_ip = lip;
    w_en = we; w_ip = wip; w_mac = wmac;
    age_tick = tick; flush = fl;
    model_lookup(lip, e_hit, e_mac);
    model_update(we, wip, wmac, tick, fl);
    @(posedge clk);
    #1;
    check("done", lookup_done, le);
    check("result", lookup_result, le && e_hit);
    check("mac", lookup_mac, (le && e_hit) ? e_mac : 48'h0);
    check("count", entry_count, model_count());
  endtask

  task automatic idle();              step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lookup(input logic [31:0] ip); step(1, ip, 0, 0, 0, 0, 0); endtask
  task automatic write(input logic [31:0] ip, input logic [47:0] mac); step(0, 0, 1, ip, mac, 0, 0); endtask
  task automatic tick();              step(0, 0, 0, 0, 0, 1, 0); endtask

  function automatic logic [31:0] ipa(input int b3, input int b2, input int b1, input int b0);
    return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  logic [31:0] ip_x;

  initial begin
    rst = 1'b1;
    lookup_en = 0; lookup_ip = '0; w_en = 0; w_ip = '0; w_mac = '0; age_tick = 0; flush = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", lookup_done, 0);
    check("rst_result", lookup_result, 0);
    check("rst_mac", lookup_mac, 0);
    check("rst_count", entry_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Empty cache misses, including the all-zero IP held by invalid entries.
    lookup(ipa(10, 0, 0, 1));
    check("empty_miss", lookup_result, 0);
    lookup(32'h0);
    check("zero_ip_miss", lookup_result, 0);

    // Learn, hit, refresh in place.
    write(ipa(10, 0, 0, 1), 48'hAAAA_AAAA_AA01);
    lookup(ipa(10, 0, 0, 1));
    check("learn_hit", lookup_result, 1);
    check("learn_mac", lookup_mac, 48'hAAAA_AAAA_AA01);
    write(ipa(10, 0, 0, 1), 48'hAAAA_AAAA_AA02);
    check("refresh_count", entry_count, 1);
    lookup(ipa(10, 0, 0, 1));
    check("refresh_mac", lookup_mac, 48'hAAAA_AAAA_AA02);

    // Fill, then round-robin replacement including pointer wrap.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) write(ipa(10, 0, 1, i), {40'h0, 8'(i)});
    check("full_count", entry_count, 8);
    write(ipa(10, 0, 1, 9), 48'h9);
    lookup(ipa(10, 0, 1, 1));
    check("evict_ip1", lookup_result, 0);
    lookup(ipa(10, 0, 1, 9));
    check("new_ip9", lookup_result, 1);
    write(ipa(10, 0, 1, 10), 48'hA);
    lookup(ipa(10, 0, 1, 2));
    check("evict_ip2", lookup_result, 0);
    for (int i = 11; i <= 16; i++) write(ipa(10, 0, 1, i), {40'h0, 8'(i)});
    write(ipa(10, 0, 1, 17), 48'h11);
    lookup(ipa(10, 0, 1, 9));
    check("wrap_evict_ip9", lookup_result, 0);
    lookup(ipa(10, 0, 1, 17));
    check("wrap_new_ip17", lookup_mac, 48'h11);

    // Aging expiry after MAX_AGE ticks.
    step(0, 0, 0, 0, 0, 0, 1);
    ip_x = ipa(10, 0, 3, 3);
    write(ip_x, 48'h33);
    tick(); tick();
    lookup(ip_x);
    check("age_2_hit", lookup_result, 1);
    tick();
    lookup(ip_x);
    check("age_3_miss", lookup_result, 0);
    check("age_count", entry_count, 0);

    // Refresh on the second tick restarts the lifetime.
    write(ip_x, 48'h34);
    tick();
    step(0, 0, 1, ip_x, 48'h35, 1, 0);
    tick(); tick();
    lookup(ip_x);
    check("refresh_alive", lookup_mac, 48'h35);
    tick();
    lookup(ip_x);
    check("refresh_expired", lookup_result, 0);

    // Same-cycle write and lookup of a new IP sees old contents.
    step(1, ipa(10, 0, 4, 4), 1, ipa(10, 0, 4, 4), 48'h44, 0, 0);
    check("wr_lk_same", lookup_result, 0);
    lookup(ipa(10, 0, 4, 4));
    check("wr_lk_after", lookup_result, 1);

    // Flush beats a same-cycle write; lookup still reports old contents.
    step(1, ipa(10, 0, 4, 4), 1, ipa(10, 0, 5, 5), 48'h55, 0, 1);
    check("flush_lk_old", lookup_result, 1);
    check("flush_count", entry_count, 0);

    // Tick at age MAX_AGE-1 together with a write of the same IP: write wins.
    write(ip_x, 48'h66);
    tick(); tick();
    step(0, 0, 1, ip_x, 48'h67, 1, 0);
    tick(); tick();
    lookup(ip_x);
    check("tick_wr_alive", lookup_mac, 48'h67);

    // Back-to-back lookups.
    for (int i = 0; i < 4; i++) begin
      lookup(ip_x);
      check("b2b_done", lookup_done, 1);
    end

    // Reset right after a lookup request drops the done pulse.
    @(negedge clk);
    lookup_en = 1; lookup_ip = ip_x; w_en = 0; age_tick = 0; flush = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_done", lookup_done, 0);
    check("rst_mid_count", entry_count, 0);
    @(negedge clk);
    check("rst_mid_done2", lookup_done, 0);
    lookup_en = 0;
    model_reset();
    rst = 1'b0;

    // Randomized traffic over a small IP pool.
    for (int n = 0; n < 400; n++) begin
      bit          le, we, tk, fl;
      logic [31:0] lip, wip;
      logic [47:0] wmac;
      le   = ($urandom_range(3) != 0);
      we   = ($urandom_range(1) != 0);
      tk   = ($urandom_range(3) == 0);
      fl   = ($urandom_range(39) == 0);
      lip  = ipa(10, 0, 2, $urandom_range(11));
      wip  = ipa(10, 0, 2, $urandom_range(11));
      wmac = {16'($urandom), 32'($urandom)};
      step(le, lip, we, wip, wmac, tk, fl);
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
